// File: rtl/change_dispenser.sv
// Vend-side change dispenser: drops the soda, then pays change as dime/nickel eject pulses.
// Inventory tracking, shortfall detection and refill exist only with CHANGE_DISPENSER_STOCK_EN defined.
module change_dispenser #(
   parameter int NICKEL_INIT  = 8,
   parameter int DIME_INIT    = 4,
   parameter int STOCK_W      = 4,
   parameter int PULSE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_soda,
   input  logic [2:0]         i_change,
   input  logic               i_refill,
   input  logic               i_mech_ready,
   output logic               o_drop_soda,
   output logic               o_eject_dime,
   output logic               o_eject_nickel,
   output logic               o_busy,
   output logic               o_short,
   output logic               o_overrun,
   output logic [STOCK_W-1:0] o_dime_stock,
   output logic [STOCK_W-1:0] o_nickel_stock
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DROP     = 3'd1,
      SELECT   = 3'd2,
      WAIT_RDY = 3'd3,
      EJECT    = 3'd4
   } state_t;

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

   state_t     state_r, state_s;
   logic [2:0] remaining_r, remaining_s;
   logic       pend_valid_r, pend_valid_s;
   logic [2:0] pend_change_r, pend_change_s;
   logic       coin_dime_r, coin_dime_s;
   logic [3:0] pulse_cnt_r, pulse_cnt_s;
   logic       overrun_r, overrun_s;
   logic       drop_r, busy_r, eject_dime_r, eject_nickel_r;
   logic       short_set_s, short_clr_s;
   logic       done_s, take_direct_s;
   logic       dime_avail_s, nickel_avail_s;

   // Next-state, coin selection and pending-slot bookkeeping
   always_comb begin
      state_s       = state_r;
      remaining_s   = remaining_r;
      pend_valid_s  = pend_valid_r;
      pend_change_s = pend_change_r;
      coin_dime_s   = coin_dime_r;
      pulse_cnt_s   = pulse_cnt_r;
      overrun_s     = overrun_r;
      short_set_s   = 1'b0;
      short_clr_s   = 1'b0;
      done_s        = 1'b0;
      take_direct_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_soda) begin
               remaining_s = i_change;
               short_clr_s = 1'b1;
               state_s     = DROP;
            end else begin
               state_s = IDLE;
            end
         end
         DROP: state_s = SELECT;
         SELECT: begin
            if (remaining_r == 3'd0) begin
               done_s = 1'b1;
            end else if ((remaining_r >= 3'd2) && dime_avail_s) begin
               coin_dime_s = 1'b1;
               remaining_s = remaining_r - 3'd2;
               state_s     = WAIT_RDY;
            end else if (nickel_avail_s) begin
               coin_dime_s = 1'b0;
               remaining_s = remaining_r - 3'd1;
               state_s     = WAIT_RDY;
            end else begin
               short_set_s = 1'b1;
               remaining_s = 3'd0;
               done_s      = 1'b1;
            end
         end
         WAIT_RDY: begin
            if (i_mech_ready) begin
               state_s     = EJECT;
               pulse_cnt_s = 4'd0;
            end else begin
               state_s = WAIT_RDY;
            end
         end
         EJECT: begin
            if (pulse_cnt_r == PULSE_LAST) begin
               state_s = SELECT;
            end else begin
               pulse_cnt_s = pulse_cnt_r + 4'd1;
            end
         end
         default: state_s = IDLE;
      endcase

      // A request landing in an empty slot on the finishing cycle is taken straight into DROP
      if (done_s) begin
         if (pend_valid_r) begin
            remaining_s  = pend_change_r;
            pend_valid_s = 1'b0;
            state_s      = DROP;
         end else if (i_soda) begin
            remaining_s   = i_change;
            take_direct_s = 1'b1;
            state_s       = DROP;
         end else begin
            state_s = IDLE;
         end
      end else begin
         take_direct_s = 1'b0;
      end

      if (i_soda && (state_r != IDLE) && !take_direct_s) begin
         if (pend_valid_r) begin
            overrun_s = 1'b1;
         end else begin
            pend_valid_s  = 1'b1;
            pend_change_s = i_change;
         end
      end else begin
         overrun_s = overrun_s;
      end
   end

   // FSM and request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         remaining_r   <= 3'd0;
         pend_valid_r  <= 1'b0;
         pend_change_r <= 3'd0;
         coin_dime_r   <= 1'b0;
         pulse_cnt_r   <= 4'd0;
         overrun_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         remaining_r   <= remaining_s;
         pend_valid_r  <= pend_valid_s;
         pend_change_r <= pend_change_s;
         coin_dime_r   <= coin_dime_s;
         pulse_cnt_r   <= pulse_cnt_s;
         overrun_r     <= overrun_s;
      end
   end

   // Outputs are decoded from the state being entered so each one comes straight from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_r         <= 1'b0;
         busy_r         <= 1'b0;
         eject_dime_r   <= 1'b0;
         eject_nickel_r <= 1'b0;
      end else begin
         drop_r         <= (state_s == DROP);
         busy_r         <= (state_s != IDLE);
         eject_dime_r   <= (state_s == EJECT) && coin_dime_s;
         eject_nickel_r <= (state_s == EJECT) && !coin_dime_s;
      end
   end

   assign o_drop_soda    = drop_r;
   assign o_busy         = busy_r;
   assign o_eject_dime   = eject_dime_r;
   assign o_eject_nickel = eject_nickel_r;
   assign o_overrun      = overrun_r;

`ifdef CHANGE_DISPENSER_STOCK_EN
   localparam logic [STOCK_W-1:0] DIME_INIT_V   = STOCK_W'(DIME_INIT);
   localparam logic [STOCK_W-1:0] NICKEL_INIT_V = STOCK_W'(NICKEL_INIT);
   localparam logic [STOCK_W-1:0] STOCK_ONE     = {{(STOCK_W-1){1'b0}}, 1'b1};
   localparam logic [STOCK_W-1:0] STOCK_ZERO    = {STOCK_W{1'b0}};

   logic [STOCK_W-1:0] dime_stock_r, nickel_stock_r;
   logic               short_r;

   assign dime_avail_s   = (dime_stock_r != STOCK_ZERO);
   assign nickel_avail_s = (nickel_stock_r != STOCK_ZERO);

   // Inventory: refill outranks the decrement taken on the first eject cycle
   always_ff @(posedge clk) begin
      if (rst || i_refill) begin
         dime_stock_r   <= DIME_INIT_V;
         nickel_stock_r <= NICKEL_INIT_V;
      end else if ((state_r == EJECT) && (pulse_cnt_r == 4'd0)) begin
         if (coin_dime_r) begin
            dime_stock_r <= dime_stock_r - STOCK_ONE;
         end else begin
            nickel_stock_r <= nickel_stock_r - STOCK_ONE;
         end
      end else begin
         dime_stock_r   <= dime_stock_r;
         nickel_stock_r <= nickel_stock_r;
      end
   end

   // Sticky shortfall flag, cleared when a new request is accepted from IDLE
   always_ff @(posedge clk) begin
      if (rst || short_clr_s) begin
         short_r <= 1'b0;
      end else if (short_set_s) begin
         short_r <= 1'b1;
      end else begin
         short_r <= short_r;
      end
   end

   assign o_short        = short_r;
   assign o_dime_stock   = dime_stock_r;
   assign o_nickel_stock = nickel_stock_r;
`else
   logic unused_s;

   assign dime_avail_s   = 1'b1;
   assign nickel_avail_s = 1'b1;
   assign unused_s       = ^{i_refill, short_set_s, short_clr_s, (NICKEL_INIT != 0), (DIME_INIT != 0)};
   assign o_short        = 1'b0;
   assign o_dime_stock   = {STOCK_W{1'b0}};
   assign o_nickel_stock = {STOCK_W{1'b0}};
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser; expected traces come from a greedy-change arithmetic model.
module tb_change_dispenser;
   localparam int P  = 2;
   localparam int DI = 4;
   localparam int NI = 8;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_soda = 1'b0;
   logic [2:0]    i_change = 3'd0;
   logic          i_refill = 1'b0;
   logic          i_mech_ready = 1'b1;
   logic          o_drop_soda, o_eject_dime, o_eject_nickel, o_busy, o_short, o_overrun;
   logic [SW-1:0] o_dime_stock, o_nickel_stock;

   int   n_cmp = 0;
   int   n_err = 0;
   int   m_dime = DI;
   int   m_nickel = NI;
   logic m_short = 1'b0;

   change_dispenser #(
      .NICKEL_INIT(NI), .DIME_INIT(DI), .STOCK_W(SW), .PULSE_CYCLES(P)
   ) dut (
      .clk(clk), .rst(rst), .i_soda(i_soda), .i_change(i_change), .i_refill(i_refill),
      .i_mech_ready(i_mech_ready), .o_drop_soda(o_drop_soda), .o_eject_dime(o_eject_dime),
      .o_eject_nickel(o_eject_nickel), .o_busy(o_busy), .o_short(o_short),
      .o_overrun(o_overrun), .o_dime_stock(o_dime_stock), .o_nickel_stock(o_nickel_stock)
   );

   always #5 clk = ~clk;

   // Expected {drop, busy, dime, nickel} in cycle T+j for k coins, the first nd being dimes
   function automatic logic [3:0] exp_trace(int j, int k, int nd);
      logic [3:0] v;
      int off, idx, r;
      v = 4'b0000;
      if (j == 1) v[3] = 1'b1;
      if (j < 3 + k * (P + 2)) v[2] = 1'b1;
      if (j >= 4) begin
         off = j - 4;
         idx = off / (P + 2);
         r   = off % (P + 2);
         if (idx < k && r < P) begin
            if (idx < nd) v[1] = 1'b1;
            else v[0] = 1'b1;
         end
      end
      return v;
   endfunction

   function automatic logic [2*SW-1:0] exp_stock();
`ifdef CHANGE_DISPENSER_STOCK_EN
      return {m_dime[SW-1:0], m_nickel[SW-1:0]};
`else
      return {(2*SW){1'b0}};
`endif
   endfunction

   function automatic logic exp_short();
`ifdef CHANGE_DISPENSER_STOCK_EN
      return m_short;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_refill();
      m_dime   = DI;
      m_nickel = NI;
   endtask

   // Issue one request from IDLE with the mechanism always ready and check the whole trace
   task automatic run_request(input int c, input string tag);
      int nd, nn, rem, k, last;
      logic [3:0] got, exp;
      logic [2*SW:0] got_st, exp_st;
      nd = c / 2;
`ifdef CHANGE_DISPENSER_STOCK_EN
      if (nd > m_dime) nd = m_dime;
`endif
      rem = c - 2 * nd;
      nn  = rem;
`ifdef CHANGE_DISPENSER_STOCK_EN
      if (nn > m_nickel) nn = m_nickel;
      m_dime   = m_dime - nd;
      m_nickel = m_nickel - nn;
`endif
      m_short = (rem > nn);
      k    = nd + nn;
      last = 3 + k * (P + 2);
      @(negedge clk);
      i_soda   = 1'b1;
      i_change = c[2:0];
      for (int j = 1; j <= last; j++) begin
         @(negedge clk);
         if (j == 1) i_soda = 1'b0;
         got = {o_drop_soda, o_busy, o_eject_dime, o_eject_nickel};
         exp = exp_trace(j, k, nd);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL %s change=%0d T+%0d drop/busy/dime/nickel: got %b want %b", tag, c, j, got, exp);
         end
      end
      got_st = {o_short, o_dime_stock, o_nickel_stock};
      exp_st = {exp_short(), exp_stock()};
      n_cmp++;
      if (got_st !== exp_st) begin
         n_err++;
         $display("FAIL %s_status short/dime/nickel: got %h want %h", tag, got_st, exp_st);
      end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      logic [2*SW-1:0] st;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_refill();
      m_short = 1'b0;
      got = {o_drop_soda, o_busy, o_eject_dime, o_eject_nickel, o_short, o_overrun};
      n_cmp++;
      if (got !== 6'b000000) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 000000", got);
      end
      st = {o_dime_stock, o_nickel_stock};
      n_cmp++;
      if (st !== exp_stock()) begin
         n_err++;
         $display("FAIL reset_stock: got %h want %h", st, exp_stock());
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      run_request(3, "basic");
      run_request(0, "zero");
      run_request(7, "max");
   endtask

   task automatic test_random();
      int c, gap;
      for (int n = 0; n < 10; n++) begin
         c   = $urandom_range(0, 7);
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         run_request(c, "random");
      end
   endtask

   task automatic test_short_refill();
      logic [2*SW-1:0] st;
      @(negedge clk);
      i_refill = 1'b1;
      @(negedge clk);
      i_refill = 1'b0;
      model_refill();
      run_request(7, "drain1");
      run_request(7, "drain2");
      run_request(7, "drain3");
      run_request(1, "short");
      @(negedge clk);
      i_refill = 1'b1;
      @(negedge clk);
      i_refill = 1'b0;
      model_refill();
      st = {o_dime_stock, o_nickel_stock};
      n_cmp++;
      if (st !== exp_stock()) begin
         n_err++;
         $display("FAIL refill_stock: got %h want %h", st, exp_stock());
      end
   endtask

   task automatic test_ready_stall();
      logic [3:0] got, exp;
      logic [1:0] ej;
      @(negedge clk);
      i_refill = 1'b1;
      @(negedge clk);
      i_refill = 1'b0;
      model_refill();
      i_mech_ready = 1'b0;
      i_soda       = 1'b1;
      i_change     = 3'd2;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         ej = {o_eject_dime, o_eject_nickel};
         n_cmp++;
         if (ej !== 2'b00 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall T+%0d eject/busy: got %b%b want 001", j, ej, o_busy);
         end
         i_soda   = (j == 3) || (j == 5);
         i_change = (j == 3) ? 3'd1 : 3'd3;
      end
      n_cmp++;
      if (o_overrun !== 1'b1) begin
         n_err++;
         $display("FAIL stall_overrun: got %b want 1", o_overrun);
      end
      i_mech_ready = 1'b1;
      for (int j = 1; j <= 2 * P + 6; j++) begin
         @(negedge clk);
         got = {o_drop_soda, o_busy, o_eject_dime, o_eject_nickel};
         exp = {(j == P + 2), (j < 2 * P + 6), (j <= P), (j >= P + 5 && j <= 2 * P + 4)};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL stall_release N+%0d drop/busy/dime/nickel: got %b want %b", j, got, exp);
         end
      end
`ifdef CHANGE_DISPENSER_STOCK_EN
      m_dime   = m_dime - 1;
      m_nickel = m_nickel - 1;
`endif
      m_short = 1'b0;
      n_cmp++;
      if ({o_overrun, o_dime_stock, o_nickel_stock} !== {1'b1, exp_stock()}) begin
         n_err++;
         $display("FAIL stall_end overrun/stock: got %b %h %h want 1 %h", o_overrun, o_dime_stock, o_nickel_stock, exp_stock());
      end
   endtask

   task automatic test_reset_mid_eject();
      logic [5:0] got;
      @(negedge clk);
      i_soda   = 1'b1;
      i_change = 3'd2;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         if (j == 1) i_soda = 1'b0;
      end
      n_cmp++;
      if (o_eject_dime !== 1'b1) begin
         n_err++;
         $display("FAIL mid_eject_active: got %b want 1", o_eject_dime);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_refill();
      m_short = 1'b0;
      got = {o_drop_soda, o_busy, o_eject_dime, o_eject_nickel, o_short, o_overrun};
      n_cmp++;
      if (got !== 6'b000000 || {o_dime_stock, o_nickel_stock} !== exp_stock()) begin
         n_err++;
         $display("FAIL mid_eject_reset flags/stock: got %b %h %h want 000000 %h", got, o_dime_stock, o_nickel_stock, exp_stock());
      end
      run_request(1, "after_rst");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_short_refill();
      test_ready_stall();
      test_reset_mid_eject();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
